// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule: emits one 32-bit expanded-key word per clock for 128/192/256-bit keys.
// Define AES_KEYEXP_RK_PACK_EN to add the packed 128-bit round-key outputs (rk_valid_o/rk_round_o/rk_out_o).

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int b = 0; b < 8; b++) begin
      if (y[b]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), built from repeated squaring.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;
  assign inv = gf_inv(a_i);
  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_sub_word #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0] w_i,
  output logic [NUM_LANES-1:0][7:0] w_o
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aes_sbox u_sbox (.a_i(w_i[l]), .s_o(w_o[l]));
  end
endmodule

module aes_rot_word (
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);
  assign w_o = {w_i[23:0], w_i[31:24]};
endmodule

module aes_key_expand_seq #(
  parameter int KEY_SIZE = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [KEY_SIZE-1:0] key_in_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                w_valid_o,
  output logic [5:0]          w_index_o,
  output logic [31:0]         w_out_o
`ifdef AES_KEYEXP_RK_PACK_EN
  ,
  output logic                rk_valid_o,
  output logic [3:0]          rk_round_o,
  output logic [127:0]        rk_out_o
`endif
);
  localparam int NK          = KEY_SIZE / 32;
  localparam int NR          = NK + 6;
  localparam int TOTAL_WORDS = 4 * (NR + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
    $error("aes_key_expand_seq: KEY_SIZE must be 128, 192 or 256");
  end

  logic [1:0]           state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic [2:0]           mod_q, mod_d, mod_nxt;
  logic [7:0]           rcon_q, rcon_d;
  // win_q[0] is w[i-Nk], win_q[NK-1] is w[i-1]
  logic [NK-1:0][31:0]  win_q, win_d;

  logic [31:0] prev_w, rot_w, sub_in, sub_w, temp_w, new_w, load_w;

  assign prev_w = win_q[NK-1];

  aes_rot_word u_rot (.w_i(prev_w), .w_o(rot_w));

  assign sub_in = (mod_q == 3'd0) ? rot_w : prev_w;

  aes_sub_word #(.NUM_LANES(4)) u_sub (.w_i(sub_in), .w_o(sub_w));

  always_comb begin
    temp_w = prev_w;
    if (mod_q == 3'd0)                 temp_w = sub_w ^ {rcon_q, 24'h0};
    else if (NK == 8 && mod_q == 3'd4) temp_w = sub_w;
  end

  assign new_w   = win_q[0] ^ temp_w;
  assign mod_nxt = (mod_q == 3'(NK-1)) ? 3'd0 : mod_q + 3'd1;

  // During LOAD the wrap counter equals the key word index.
  always_comb begin
    load_w = 32'h0;
    for (int j = 0; j < NK; j++)
      if (mod_q == 3'(j)) load_w = win_q[j];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          idx_d   = 6'd0;
          mod_d   = 3'd0;
          rcon_d  = 8'h01;
          for (int j = 0; j < NK; j++) win_d[j] = key_in_i[KEY_SIZE-1-32*j -: 32];
        end
      end
      S_LOAD: begin
        idx_d = idx_q + 6'd1;
        mod_d = mod_nxt;
        if (mod_q == 3'(NK-1)) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        idx_d = idx_q + 6'd1;
        mod_d = mod_nxt;
        win_d = {new_w, win_q[NK-1:1]};
        if (mod_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (idx_q == 6'(TOTAL_WORDS-1)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      mod_q   <= 3'd0;
      rcon_q  <= 8'h01;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      win_q   <= win_d;
    end
  end

  assign busy_o    = (state_q == S_LOAD) || (state_q == S_EXPAND);
  assign w_valid_o = busy_o;
  assign done_o    = (state_q == S_FINISH);
  assign w_index_o = busy_o ? idx_q : 6'd0;
  assign w_out_o   = (state_q == S_LOAD)   ? load_w :
                     (state_q == S_EXPAND) ? new_w  : 32'h0;

`ifdef AES_KEYEXP_RK_PACK_EN
  logic [3:0][31:0] rk_hold_q;
  logic             rk_valid_q;
  logic [3:0]       rk_round_q;
  logic             rk_last;

  assign rk_last = w_valid_o && (w_index_o[1:0] == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rk_hold_q  <= '0;
      rk_valid_q <= 1'b0;
      rk_round_q <= 4'd0;
    end else begin
      rk_valid_q <= rk_last;
      if (w_valid_o) rk_hold_q[w_index_o[1:0]] <= w_out_o;
      if (rk_last)   rk_round_q <= w_index_o[5:2];
    end
  end

  assign rk_valid_o = rk_valid_q;
  assign rk_round_o = rk_round_q;
  assign rk_out_o   = {rk_hold_q[0], rk_hold_q[1], rk_hold_q[2], rk_hold_q[3]};
`endif
endmodule
